// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory command port.
// Round-robin on ties, one access in flight, all outputs registered.
module mem_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ack,
  output logic [31:0]      if_rdata,
  input  logic             dm_req,
  input  logic [2:0]       dm_rd_ctrl,
  input  logic [1:0]       dm_wr_ctrl,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_din,
  output logic             dm_ack,
  output logic             dm_err,
  output logic [31:0]      dm_dout,
  output logic             m_en,
  output logic [31:0]      m_addr,
  output logic [2:0]       m_rd_ctrl,
  output logic [1:0]       m_wr_ctrl,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] if_cnt,
  output logic [CNT_W-1:0] dm_cnt
);

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_dm_q, last_dm_d;
  logic               sel_dm_q, sel_dm_d;
  logic               if_ack_q, if_ack_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic               dm_ack_q, dm_ack_d;
  logic               dm_err_q, dm_err_d;
  logic [31:0]        dm_dout_q, dm_dout_d;
  logic               m_en_q, m_en_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [2:0]         m_rd_ctrl_q, m_rd_ctrl_d;
  logic [1:0]         m_wr_ctrl_q, m_wr_ctrl_d;
  logic [31:0]        m_wdata_q, m_wdata_d;
  logic [CNT_W-1:0]   if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0]   dm_cnt_q, dm_cnt_d;

  logic dm_bad, dm_noop, grant_dm;

  // Data command legality, evaluated on the live inputs in IDLE
  always_comb begin
    dm_noop = (dm_rd_ctrl == RD_NONE) && (dm_wr_ctrl == WR_NONE);
    dm_bad  = (dm_rd_ctrl[2:1] == 2'b11)
            || ((dm_rd_ctrl != RD_NONE) && (dm_wr_ctrl != WR_NONE))
            || (((dm_rd_ctrl == RD_LW) || (dm_wr_ctrl == WR_SW)) && (dm_addr[1:0] != 2'b00))
            || (((dm_rd_ctrl == RD_LH) || (dm_rd_ctrl == RD_LHU) || (dm_wr_ctrl == WR_SH))
                && dm_addr[0]);
  end

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    sel_dm_d    = sel_dm_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    dm_dout_d   = dm_dout_q;
    m_en_d      = 1'b0;
    m_addr_d    = 32'h0;
    m_rd_ctrl_d = RD_NONE;
    m_wr_ctrl_d = WR_NONE;
    m_wdata_d   = 32'h0;
    if_cnt_d    = if_cnt_q;
    dm_cnt_d    = dm_cnt_q;
    grant_dm    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_dm  = dm_req && (!if_req || !last_dm_q);
          last_dm_d = grant_dm;
          sel_dm_d  = grant_dm;
          if (!grant_dm) begin
            state_d     = ISSUE;
            m_en_d      = 1'b1;
            m_addr_d    = if_addr;
            m_rd_ctrl_d = RD_LW;
          end else if (dm_bad || dm_noop) begin
            // Nothing reaches memory; answer directly
            state_d   = RESP;
            dm_ack_d  = 1'b1;
            dm_err_d  = dm_bad;
            dm_dout_d = 32'h0;
            dm_cnt_d  = dm_cnt_q + CNT_W'(1);
          end else begin
            state_d     = ISSUE;
            m_en_d      = 1'b1;
            m_addr_d    = dm_addr;
            m_rd_ctrl_d = dm_rd_ctrl;
            m_wr_ctrl_d = dm_wr_ctrl;
            m_wdata_d   = dm_din;
          end
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (sel_dm_q) begin
          dm_ack_d  = 1'b1;
          dm_dout_d = m_rdata;
          dm_cnt_d  = dm_cnt_q + CNT_W'(1);
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = m_rdata;
          if_cnt_d   = if_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b0;
      sel_dm_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_dout_q   <= 32'h0;
      m_en_q      <= 1'b0;
      m_addr_q    <= 32'h0;
      m_rd_ctrl_q <= RD_NONE;
      m_wr_ctrl_q <= WR_NONE;
      m_wdata_q   <= 32'h0;
      if_cnt_q    <= '0;
      dm_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      sel_dm_q    <= sel_dm_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      dm_dout_q   <= dm_dout_d;
      m_en_q      <= m_en_d;
      m_addr_q    <= m_addr_d;
      m_rd_ctrl_q <= m_rd_ctrl_d;
      m_wr_ctrl_q <= m_wr_ctrl_d;
      m_wdata_q   <= m_wdata_d;
      if_cnt_q    <= if_cnt_d;
      dm_cnt_q    <= dm_cnt_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign dm_dout   = dm_dout_q;
  assign m_en      = m_en_q;
  assign m_addr    = m_addr_q;
  assign m_rd_ctrl = m_rd_ctrl_q;
  assign m_wr_ctrl = m_wr_ctrl_q;
  assign m_wdata   = m_wdata_q;
  assign if_cnt    = if_cnt_q;
  assign dm_cnt    = dm_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory commands and
// acks; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  // Narrow counters so the wrap-around is reachable in a short run
  localparam int unsigned CW  = 10;
  localparam logic [31:0] KEY = 32'h0011_2223;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic [2:0]    dm_rd_ctrl;
  logic [1:0]    dm_wr_ctrl;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_din;
  logic          dm_ack;
  logic          dm_err;
  logic [31:0]   dm_dout;
  logic          m_en;
  logic [31:0]   m_addr;
  logic [2:0]    m_rd_ctrl;
  logic [1:0]    m_wr_ctrl;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic [CW-1:0] if_cnt;
  logic [CW-1:0] dm_cnt;

  mem_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_ack(dm_ack), .dm_err(dm_err),
    .dm_dout(dm_dout), .m_en(m_en), .m_addr(m_addr), .m_rd_ctrl(m_rd_ctrl),
    .m_wr_ctrl(m_wr_ctrl), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .if_cnt(if_cnt), .dm_cnt(dm_cnt)
  );

  // Memory read data is a fixed function of the address
  assign m_rdata = m_addr ^ KEY;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] wdata;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic          is_dm;
    logic [31:0]   data;
    logic          err;
    logic [CW-1:0] cnt;
    int            cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  logic [CW-1:0] mdl_if_cnt = '0;
  logic [CW-1:0] mdl_dm_cnt = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] wd, input int c);
    cmd_t e;
    e.addr = a; e.rd = rd; e.wr = wr; e.wdata = wd; e.cyc = c;
    cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input logic is_dm, input logic [31:0] d, input logic err, input int c);
    rsp_t e;
    if (is_dm) begin
      mdl_dm_cnt = mdl_dm_cnt + CW'(1);
      e.cnt = mdl_dm_cnt;
    end else begin
      mdl_if_cnt = mdl_if_cnt + CW'(1);
      e.cnt = mdl_if_cnt;
    end
    e.is_dm = is_dm; e.data = d; e.err = err; e.cyc = c;
    rsp_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard
  always @(negedge clk) begin
    if (m_en) begin
      if (cmd_q.size() == 0) begin
        chk("unexpected m_en", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        chk("m_cmd", {m_addr, 3'(m_rd_ctrl), 2'(m_wr_ctrl), 27'(m_wdata[26:0])},
                     {e.addr, e.rd, e.wr, 27'(e.wdata[26:0])});
        chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
        chk("m_cyc", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("m_bus_idle", {m_addr, m_wdata}, 64'h0);
      chk("m_ctrl_idle", 64'({m_rd_ctrl, m_wr_ctrl}), 64'h0);
    end
    if (!dm_ack) chk("dm_err_idle", 64'(dm_err), 64'h0);
    if (if_ack || dm_ack) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected ack", 64'({if_ack, dm_ack}), 64'h0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("ack_port", 64'({if_ack, dm_ack}), r.is_dm ? 64'h1 : 64'h2);
        chk("ack_cyc", 64'(cyc), 64'(r.cyc));
        if (r.is_dm) begin
          chk("dm_dout", 64'(dm_dout), 64'(r.data));
          chk("dm_err", 64'(dm_err), 64'(r.err));
          chk("dm_cnt", 64'(dm_cnt), 64'(r.cnt));
        end else begin
          chk("if_rdata", 64'(if_rdata), 64'(r.data));
          chk("if_cnt", 64'(if_cnt), 64'(r.cnt));
        end
      end
    end
  end

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_rd_ctrl = 3'b000; dm_wr_ctrl = 2'b00;
    dm_addr = 32'h0; dm_din = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acks"}, 64'({if_ack, dm_ack, dm_err, m_en}), 64'h0);
    chk({tag, "_data"}, {if_rdata, dm_dout}, 64'h0);
    chk({tag, "_cnts"}, 64'({if_cnt, dm_cnt}), 64'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that ends the last RESP
  task automatic drain(input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
      chk("drain_timeout", 64'(cmd_q.size() + rsp_q.size()), 64'h0);
      cmd_q.delete();
      rsp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_if_cnt = '0;
    mdl_dm_cnt = '0;
  endtask

  task automatic if_op(input logic [31:0] a, input logic [31:0] rdata);
    if_req = 1'b1; if_addr = a;
    push_cmd(a, 3'b101, 2'b00, 32'h0, cyc + 1);
    push_rsp(1'b0, rdata, 1'b0, cyc + 2);
    drain(20);
    drive_idle();
  endtask

  task automatic dm_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] din, input logic issued, input logic err,
                       input logic [31:0] dout);
    dm_req = 1'b1; dm_rd_ctrl = rd; dm_wr_ctrl = wr; dm_addr = a; dm_din = din;
    if (issued) begin
      push_cmd(a, rd, wr, din, cyc + 1);
      push_rsp(1'b1, dout, 1'b0, cyc + 2);
    end else begin
      push_rsp(1'b1, dout, err, cyc + 1);
    end
    drain(20);
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Single fetch
    if_op(32'h10, 32'h0011_2233);

    // Tie from reset: DM, IF, DM while both held
    do_reset();
    begin
      int k;
      k = cyc;
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_rd_ctrl = 3'b101; dm_addr = 32'h80; dm_din = 32'h55;
      push_cmd(32'h80, 3'b101, 2'b00, 32'h55, k + 1);
      push_rsp(1'b1, 32'h0011_22A3, 1'b0, k + 2);
      push_cmd(32'h40, 3'b101, 2'b00, 32'h0, k + 4);
      push_rsp(1'b0, 32'h0011_2263, 1'b0, k + 5);
      push_cmd(32'h80, 3'b101, 2'b00, 32'h55, k + 7);
      push_rsp(1'b1, 32'h0011_22A3, 1'b0, k + 8);
      drain(30);
      drive_idle();
    end

    // Data error and legal cases
    dm_op(3'b000, 2'b11, 32'h103, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
    dm_op(3'b000, 2'b10, 32'h202, 32'h1234,      1'b1, 1'b0, 32'h0011_2021);
    dm_op(3'b001, 2'b00, 32'h101, 32'h0,         1'b1, 1'b0, 32'h0011_2322);
    dm_op(3'b011, 2'b00, 32'h201, 32'h0,         1'b0, 1'b1, 32'h0);
    dm_op(3'b110, 2'b00, 32'h100, 32'h0,         1'b0, 1'b1, 32'h0);
    dm_op(3'b101, 2'b11, 32'h100, 32'h77,        1'b0, 1'b1, 32'h0);
    dm_op(3'b000, 2'b00, 32'h104, 32'h0,         1'b0, 1'b0, 32'h0);

    // Last grant was DM, so a tie now goes to IF first
    begin
      int k;
      k = cyc;
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_rd_ctrl = 3'b001; dm_addr = 32'h101;
      push_cmd(32'h10, 3'b101, 2'b00, 32'h0, k + 1);
      push_rsp(1'b0, 32'h0011_2233, 1'b0, k + 2);
      push_cmd(32'h101, 3'b001, 2'b00, 32'h0, k + 4);
      push_rsp(1'b1, 32'h0011_2322, 1'b0, k + 5);
      drain(30);
      drive_idle();
    end

    // Reset while a fetch is in ISSUE: no ack, everything cleared
    begin
      if_req = 1'b1; if_addr = 32'h20;
      push_cmd(32'h20, 3'b101, 2'b00, 32'h0, cyc + 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      mdl_if_cnt = '0;
      mdl_dm_cnt = '0;
      @(negedge clk);
      check_all_zero("rst_in_issue");
      chk("rst_cmd_seen", 64'(cmd_q.size()), 64'h0);
      repeat (4) @(posedge clk);
      #1;
    end

    // Counter wrap via back-to-back no-ops
    do_reset();
    begin
      int k;
      k = cyc;
      dm_req = 1'b1;
      for (int i = 0; i < (1 << CW); i++) push_rsp(1'b1, 32'h0, 1'b0, k + 1 + 2 * i);
      drain(2 * (1 << CW) + 20);
      drive_idle();
      @(negedge clk);
      chk("dm_cnt_wrapped", 64'(dm_cnt), 64'h0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
